// File: rtl/exec_muldiv_pkg.sv
// Shared pipeline types for the Execute-stage multiply/divide unit.
// Opcode and FSM encodings plus the iteration count.
package exec_muldiv_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } md_state_e;

  typedef struct packed {
    logic isdiv;
    logic signa;
    logic signb;
  } md_ctx_t;

endpackage

// File: rtl/md_absneg.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and result sign fix-up.
module md_absneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/exec_muldiv.sv
// Iterative multiply/divide unit for the Execute stage.
// 32-cycle shift-add multiply and restoring divide writing HI/LO.
module exec_muldiv
  import exec_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  output logic        stallE,
  output logic        doneE,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divzero
);

  localparam int CW = $clog2(MD_ITER);

  md_state_e      state;
  md_ctx_t        ctx;
  logic [CW-1:0]  cnt;
  logic [63:0]    acc;
  logic [31:0]    rem;
  logic [31:0]    dvs;

  logic           sgn_op;
  logic [31:0]    amag;
  logic [31:0]    bmag;
  logic [63:0]    prod;
  logic [31:0]    quo;
  logic [31:0]    rmd;
  logic [32:0]    msum;
  logic [32:0]    rsh;
  logic [32:0]    trial;

  assign sgn_op = (opE == MD_MULT) || (opE == MD_DIV);

  md_absneg #(.W(32)) u_absa (
    .a   (srcaE),
    .neg (sgn_op & srcaE[31]),
    .y   (amag)
  );

  md_absneg #(.W(32)) u_absb (
    .a   (srcbE),
    .neg (sgn_op & srcbE[31]),
    .y   (bmag)
  );

  md_absneg #(.W(64)) u_prod (
    .a   (acc),
    .neg (ctx.signa ^ ctx.signb),
    .y   (prod)
  );

  md_absneg #(.W(32)) u_quo (
    .a   (acc[31:0]),
    .neg (ctx.signa ^ ctx.signb),
    .y   (quo)
  );

  md_absneg #(.W(32)) u_rmd (
    .a   (rem),
    .neg (ctx.signa),
    .y   (rmd)
  );

  // acc = {partial product, unconsumed multiplier bits}
  assign msum  = {1'b0, acc[63:32]}
               + (acc[0] ? {1'b0, dvs} : 33'd0);
  assign rsh   = {rem, acc[31]};
  assign trial = rsh - {1'b0, dvs};

  assign stallE = rst_n & (
      ((state == IDLE) & startE & ~flushE)
    | (state == MUL)
    | (state == DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ctx     <= '0;
      cnt     <= '0;
      acc     <= '0;
      rem     <= '0;
      dvs     <= '0;
      hi      <= '0;
      lo      <= '0;
      divzero <= 1'b0;
      doneE   <= 1'b0;
    end else begin
      doneE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (startE && !flushE) begin
            ctx.isdiv <= opE[1];
            ctx.signa <= sgn_op & srcaE[31];
            ctx.signb <= sgn_op & srcbE[31];
            acc       <= {32'd0, amag};
            rem       <= '0;
            dvs       <= bmag;
            cnt       <= CW'(MD_ITER - 1);
            state     <= opE[1] ? DIV : MUL;
          end
        end
        MUL: begin
          if (flushE) begin
            state <= IDLE;
          end else begin
            acc <= {msum, acc[31:1]};
            cnt <= cnt - CW'(1);
            if (cnt == '0) state <= DONE;
          end
        end
        DIV: begin
          if (flushE) begin
            state <= IDLE;
          end else begin
            rem <= trial[32] ? rsh[31:0] : trial[31:0];
            acc <= {32'd0, acc[30:0], ~trial[32]};
            cnt <= cnt - CW'(1);
            if (cnt == '0) state <= DONE;
          end
        end
        DONE: begin
          if (!flushE) begin
            if (ctx.isdiv) begin
              hi      <= rmd;
              lo      <= quo;
              divzero <= (dvs == '0);
            end else begin
              {hi, lo} <= prod;
              divzero  <= 1'b0;
            end
            doneE <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_muldiv.sv
// Self-checking bench for exec_muldiv.
// Directed vectors, multi-cycle corner sequences and random ops.
module tb_exec_muldiv;

  logic        clk;
  logic        rst_n;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        stallE;
  logic        doneE;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divzero;

  int errors = 0;
  int checks = 0;

  exec_muldiv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .startE  (startE),
    .opE     (opE),
    .srcaE   (srcaE),
    .srcbE   (srcbE),
    .flushE  (flushE),
    .stallE  (stallE),
    .doneE   (doneE),
    .hi      (hi),
    .lo      (lo),
    .divzero (divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] mhi,
                                output logic [31:0] mlo,
                                output logic mdz);
    logic [63:0] p;
    mdz = 1'b0;
    mhi = '0;
    mlo = '0;
    case (op)
      2'b00: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        {mhi, mlo} = p;
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        {mhi, mlo} = p;
      end
      2'b10: begin
        if (b == 0) begin
          mdz = 1'b1;
          mlo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
          mhi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          mlo = 32'h8000_0000;
          mhi = 32'd0;
        end else begin
          mlo = 32'($signed(a) / $signed(b));
          mhi = 32'($signed(a) % $signed(b));
        end
      end
      default: begin
        if (b == 0) begin
          mdz = 1'b1;
          mlo = 32'hFFFF_FFFF;
          mhi = a;
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
      end
    endcase
  endfunction

  // Called just after a rising edge with the unit idle.
  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int lat,
                        output int stl);
    startE = 1'b1;
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    lat    = 0;
    stl    = 0;
    #1;
    if (stallE) stl++;
    @(posedge clk);
    #1;
    startE = 1'b0;
    lat    = 1;
    while (!doneE && lat < 100) begin
      if (stallE) stl++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) begin
      errors++;
      checks++;
      $display("FAIL timeout: no doneE within %0d cycles", lat);
    end
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (!doneE && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int lat;
    int stl;
    int n;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vt[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vt[1]  = '{2'b00, 32'hFFFF_FFF9, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vt[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vt[3]  = '{2'b11, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0};
    vt[4]  = '{2'b11, 32'd5, 32'd0,
               32'd5, 32'hFFFF_FFFF, 1'b1};
    vt[5]  = '{2'b01, 32'd2, 32'd3,
               32'd0, 32'd6, 1'b0};
    vt[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'd0, 1'b0};
    vt[7]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 1'b0};
    vt[8]  = '{2'b10, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD, 1'b0};
    vt[9]  = '{2'b11, 32'hFFFF_FFFF, 32'd1,
               32'd0, 32'hFFFF_FFFF, 1'b0};
    vt[10] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 1'b0};

    rst_n  = 1'b0;
    startE = 1'b1;
    flushE = 1'b0;
    opE    = 2'b01;
    srcaE  = 32'd3;
    srcbE  = 32'd4;
    #1;
    check("stall_in_reset", 64'(stallE), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dz", 64'(divzero), 64'd0);
    check("rst_done", 64'(doneE), 64'd0);
    check("rst_stall", 64'(stallE), 64'd0);
    startE = 1'b0;
    rst_n  = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, lat, stl);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vt[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vt[i].lo));
      check($sformatf("vec%0d_dz", i), 64'(divzero), 64'(vt[i].dz));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd34);
      check($sformatf("vec%0d_stall", i), 64'(stl), 64'd33);
    end

    // Flush a divide mid-flight with HI/LO = 2/3.
    run_op(2'b11, 32'd11, 32'd3, lat, stl);
    check("pre_flush_hi", 64'(hi), 64'd2);
    check("pre_flush_lo", 64'(lo), 64'd3);
    startE = 1'b1;
    opE    = 2'b10;
    srcaE  = 32'd100;
    srcbE  = 32'd7;
    @(posedge clk);
    #1;
    startE = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flushE = 1'b1;
    #1;
    check("flush_stall_before", 64'(stallE), 64'd1);
    @(posedge clk);
    #1;
    flushE = 1'b0;
    #1;
    check("flush_stall_after", 64'(stallE), 64'd0);
    check("flush_done", 64'(doneE), 64'd0);
    check("flush_hi", 64'(hi), 64'd2);
    check("flush_lo", 64'(lo), 64'd3);
    run_op(2'b01, 32'd4, 32'd5, lat, stl);
    check("post_flush_lo", 64'(lo), 64'd20);
    check("post_flush_lat", 64'(lat), 64'd34);

    // Flush while in DONE suppresses the write-back.
    startE = 1'b1;
    opE    = 2'b01;
    srcaE  = 32'd9;
    srcbE  = 32'd9;
    @(posedge clk);
    #1;
    startE = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("done_stall_low", 64'(stallE), 64'd0);
    flushE = 1'b1;
    @(posedge clk);
    #1;
    flushE = 1'b0;
    check("doneflush_done", 64'(doneE), 64'd0);
    check("doneflush_lo", 64'(lo), 64'd20);
    check("doneflush_hi", 64'(hi), 64'd0);

    // Start together with flush in IDLE is dropped.
    startE = 1'b1;
    flushE = 1'b1;
    #1;
    check("startflush_stall", 64'(stallE), 64'd0);
    @(posedge clk);
    #1;
    startE = 1'b0;
    flushE = 1'b0;
    #1;
    check("startflush_idle", 64'(stallE), 64'd0);

    // startE held high while busy must not restart the op.
    startE = 1'b1;
    opE    = 2'b01;
    srcaE  = 32'd6;
    srcbE  = 32'd7;
    @(posedge clk);
    #1;
    opE   = 2'b11;
    srcaE = 32'd1000;
    srcbE = 32'd3;
    repeat (32) @(posedge clk);
    #1;
    startE = 1'b0;
    wait_done(5, n);
    check("busy_start_done", 64'(doneE), 64'd1);
    check("busy_start_lo", 64'(lo), 64'd42);
    check("busy_start_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ((i % 8) == 3) rb = 32'($urandom_range(0, 15));
      if ((i % 8) == 5) ra = 32'h8000_0000;
      model(rop, ra, rb, ehi, elo, edz);
      run_op(rop, ra, rb, lat, stl);
      check($sformatf("rnd%0d_hi", i), 64'(hi), 64'(ehi));
      check($sformatf("rnd%0d_lo", i), 64'(lo), 64'(elo));
      check($sformatf("rnd%0d_dz", i), 64'(divzero), 64'(edz));
    end

    // Reset in the middle of a multiply.
    run_op(2'b01, 32'd5, 32'd7, lat, stl);
    startE = 1'b1;
    opE    = 2'b00;
    srcaE  = 32'd123;
    srcbE  = 32'd456;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_stall", 64'(stallE), 64'd0);
    @(posedge clk);
    #1;
    startE = 1'b0;
    rst_n  = 1'b1;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, stl);
    check("postrst_lo", 64'(lo), 64'h8000_0000);
    check("postrst_hi", 64'(hi), 64'd0);
    check("postrst_lat", 64'(lat), 64'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
